beat_loop_ctrl: RTL and testbench
=================================

// Module: beat_loop_ctrl
// PURPOSE
//  Parametrised multi-track mode controller for the beat recorder. Generalises the single-buffer
//  free-play/record/play controller to NUM_TRACKS loop tracks sharing one loop length, and adds
//  overdub, tick-aligned recording, loop wrap and clear. Drives the track RAM, the buzzer mixer
//  and the HEX state display.
// PARAMETERS
//  NUM_TRACKS  4   number of loop tracks; TRK_W = $clog2(NUM_TRACKS) (localparam, min 1)
//  ADDR_W      10  RAM address width; DEPTH = 2**ADDR_W samples per track
// PORTS
//  CLOCK_50        in   1           system clock
//  reset           in   1           synchronous, active-high reset
//  tick            in   1           one-cycle sample strobe
//  mode_req        in   2           00 free, 01 record, 10 play, 11 overdub
//  track_sel       in   TRK_W       target track for record/overdub
//  clear           in   1           erase loop length and all track-valid bits
//  ram_we          out  1           RAM write enable, one cycle per written sample
//  ram_addr        out  ADDR_W      RAM sample address (addr register)
//  ram_track       out  TRK_W       RAM track index for the write (latched track)
//  keyboard_record out  1           1 = live keyboard routed into RAM data
//  play_mask       out  NUM_TRACKS  tracks the mixer reads back
//  loop_len        out  ADDR_W+1    loop length in samples; 0 = no loop
//  state_code      out  4           FREE 0, RECORD 1, OVERDUB 2, PLAY 3, ARM 4 (to HEX)
//  overflow        out  1           sticky: first recording hit DEPTH
// BEHAVIOUR
//  - Reset: state FREE, addr 0, loop_len 0, track_valid 0, overflow 0, trk 0; all outputs 0.
//  - One registered FSM; mode_req changes state on the next clock edge (1-cycle latency).
//  - trk latched from track_sel on entry to ARM or OVERDUB; later track_sel changes ignored.
//  - FREE: 01 -> ARM; 10 -> PLAY if loop_len!=0, else stay; 11 -> OVERDUB if loop_len!=0,
//    else stay; addr <= 0. clear honoured only in FREE: loop_len, track_valid, overflow <= 0.
//  - ARM: mode_req!=01 -> FREE. On tick -> RECORD, addr <= 0. No write in ARM.
//  - RECORD, loop_len==0 (first take): each tick writes at addr, then addr++.
//    The write at addr==DEPTH-1 sets loop_len <= DEPTH, overflow <= 1,
//    track_valid[trk] <= 1 and returns the FSM to FREE.
//    Release (mode_req!=01) -> FREE with loop_len <= addr. If addr!=0, track_valid[trk] <= 1.
//  - RECORD, loop_len!=0: writes on tick. addr wraps loop_len-1 -> 0. Runs until release.
//    track_valid[trk] <= 1 on the first write.
//  - PLAY: tick advances addr, wrapping loop_len-1 -> 0. play_mask = track_valid.
//    mode_req!=10 -> FREE.
//  - OVERDUB: addr advances as in PLAY. Each tick writes at addr on trk.
//    play_mask = track_valid & ~onehot(trk). track_valid[trk] <= 1. mode_req!=11 -> FREE.
//  - ram_we = tick & (state RECORD|OVERDUB) & (mode_req still selects that mode).
//    A tick in the same cycle as release is not written.
//  - keyboard_record = 1 in RECORD and OVERDUB; play_mask = 0 in FREE, ARM and RECORD.
//  - Direct mode switches (e.g. PLAY -> OVERDUB) pass through FREE; addr resets to 0.
//  - Reset mid-operation returns everything to reset values; RAM contents are untouched
//    but treated as invalid.
//  - Illegal state encodings -> FREE.
// TESTING
//  - Reset -> state_code 0, loop_len 0, play_mask 0, ram_we 0.
//  - Record: mode_req=01, track_sel=0, 5 ticks, release -> ARM then RECORD, ram_addr 0..4
//    written, loop_len=5, track_valid=0001, state FREE.
//  - Play with loop_len=5: 12 ticks -> ram_addr 0,1,2,3,4,0,1,...,1, play_mask=0001, ram_we never 1.
//  - Overdub track 2 with loop_len=5: 7 ticks -> writes at 0..4,0,1 on ram_track 2,
//    play_mask=0001 during overdub, track_valid=0101 after.
//  - Overflow with ADDR_W=3: record 8 ticks -> loop_len=8, overflow=1, auto FREE;
//    a 9th tick writes nothing.
//  - Edge cases: tick coincident with release drops the write; clear in PLAY is ignored;
//    clear in FREE zeroes loop_len and track_valid; mode_req=10 with loop_len=0 stays FREE.

Source files
------------

// File: rtl/beat_loop_ctrl.sv
// beat_loop_ctrl
//   Multi-track mode controller for the beat recorder. NUM_TRACKS loop tracks
//   share one loop length. The controller supports free play, record (with a
//   tick-aligned ARM stage), play, overdub, loop wrap and clear. It drives the
//   track RAM, the buzzer mixer and the HEX state display.
//
// Parameters
//   NUM_TRACKS  number of loop tracks (TRK_W = $clog2(NUM_TRACKS), min 1)
//   ADDR_W      RAM address width; DEPTH = 2**ADDR_W samples per track
//
// Ports
//   CLOCK_50         in   system clock
//   reset            in   synchronous, active-high reset
//   tick             in   one-cycle sample strobe
//   mode_req         in   00 free, 01 record, 10 play, 11 overdub
//   track_sel        in   target track for record/overdub (latched on entry)
//   clear            in   erase loop length, track-valid bits and overflow (FREE only)
//   ram_we           out  RAM write enable, one cycle per written sample
//   ram_addr         out  RAM sample address
//   ram_track        out  RAM track index for the write
//   keyboard_record  out  live keyboard routed into RAM data
//   play_mask        out  tracks the mixer reads back
//   loop_len         out  loop length in samples; 0 = no loop
//   state_code       out  FREE 0, RECORD 1, OVERDUB 2, PLAY 3, ARM 4
//   overflow         out  sticky: first recording filled the whole track
module beat_loop_ctrl #(
  parameter int NUM_TRACKS = 4,
  parameter int ADDR_W     = 10,
  localparam int TRK_W     = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  tick,
  input  logic [1:0]            mode_req,
  input  logic [TRK_W-1:0]      track_sel,
  input  logic                  clear,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [TRK_W-1:0]      ram_track,
  output logic                  keyboard_record,
  output logic [NUM_TRACKS-1:0] play_mask,
  output logic [ADDR_W:0]       loop_len,
  output logic [3:0]            state_code,
  output logic                  overflow
);

  typedef enum logic [2:0] {
    ST_FREE    = 3'd0,
    ST_RECORD  = 3'd1,
    ST_OVERDUB = 3'd2,
    ST_PLAY    = 3'd3,
    ST_ARM     = 3'd4
  } state_e;

  localparam logic [1:0] MODE_FREE = 2'b00;
  localparam logic [1:0] MODE_REC  = 2'b01;
  localparam logic [1:0] MODE_PLAY = 2'b10;
  localparam logic [1:0] MODE_ODUB = 2'b11;

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [ADDR_W:0]         len_q, len_d;
  logic [NUM_TRACKS-1:0]   valid_q, valid_d;
  logic                    ovf_q, ovf_d;
  logic [TRK_W-1:0]        trk_q, trk_d;

  logic                    write_en;
  logic                    loop_present;
  logic [NUM_TRACKS-1:0]   trk_onehot;

  function automatic logic [NUM_TRACKS-1:0] onehot(input logic [TRK_W-1:0] t);
    return NUM_TRACKS'(1) << t;
  endfunction

  // Advance within the loop; wraps at loop_len-1. The >= guards against an
  // address that somehow sits beyond the loop end.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W:0]   len);
    if ({1'b0, a} >= (len - (ADDR_W+1)'(1))) return '0;
    return a + ADDR_W'(1);
  endfunction

  assign loop_present = (len_q != '0);
  assign trk_onehot   = onehot(trk_q);

  // A tick in the same cycle as a release is not written: the mode request
  // must still select the active writing mode.
  assign write_en = tick &&
                    (((state_q == ST_RECORD)  && (mode_req == MODE_REC)) ||
                     ((state_q == ST_OVERDUB) && (mode_req == MODE_ODUB)));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    trk_d   = trk_q;

    case (state_q)
      ST_FREE: begin
        addr_d = '0;
        if (clear) begin
          len_d   = '0;
          valid_d = '0;
          ovf_d   = 1'b0;
        end
        // A clear in the same cycle wins over entering a loop-based mode,
        // so PLAY/OVERDUB never start with a zero loop length.
        case (mode_req)
          MODE_REC: begin
            state_d = ST_ARM;
            trk_d   = track_sel;
          end
          MODE_PLAY: begin
            if (loop_present && !clear) state_d = ST_PLAY;
          end
          MODE_ODUB: begin
            if (loop_present && !clear) begin
              state_d = ST_OVERDUB;
              trk_d   = track_sel;
            end
          end
          default: ;
        endcase
      end

      ST_ARM: begin
        if (mode_req != MODE_REC) begin
          state_d = ST_FREE;
          addr_d  = '0;
        end else if (tick) begin
          state_d = ST_RECORD;
          addr_d  = '0;
        end
      end

      ST_RECORD: begin
        if (mode_req != MODE_REC) begin
          state_d = ST_FREE;
          addr_d  = '0;
          if (!loop_present) begin
            // First take: the number of samples written becomes the loop.
            len_d = {1'b0, addr_q};
            if (addr_q != '0) valid_d = valid_q | trk_onehot;
          end
        end else if (write_en) begin
          if (!loop_present) begin
            if (addr_q == ADDR_LAST) begin
              // Track full: close the loop at DEPTH and stop recording.
              len_d   = DEPTH_LEN;
              ovf_d   = 1'b1;
              valid_d = valid_q | trk_onehot;
              state_d = ST_FREE;
              addr_d  = '0;
            end else begin
              addr_d = addr_q + ADDR_W'(1);
            end
          end else begin
            valid_d = valid_q | trk_onehot;
            addr_d  = next_addr(addr_q, len_q);
          end
        end
      end

      ST_PLAY: begin
        if (mode_req != MODE_PLAY) begin
          state_d = ST_FREE;
          addr_d  = '0;
        end else if (tick) begin
          addr_d = next_addr(addr_q, len_q);
        end
      end

      ST_OVERDUB: begin
        if (mode_req != MODE_ODUB) begin
          state_d = ST_FREE;
          addr_d  = '0;
        end else if (write_en) begin
          valid_d = valid_q | trk_onehot;
          addr_d  = next_addr(addr_q, len_q);
        end
      end

      default: begin
        state_d = ST_FREE;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_FREE;
      addr_q  <= '0;
      len_q   <= '0;
      valid_q <= '0;
      ovf_q   <= 1'b0;
      trk_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      trk_q   <= trk_d;
    end
  end

  always_comb begin
    keyboard_record = 1'b0;
    play_mask       = '0;
    case (state_q)
      ST_RECORD:  keyboard_record = 1'b1;
      ST_OVERDUB: begin
        keyboard_record = 1'b1;
        // The track being overdubbed is muted in the mix.
        play_mask       = valid_q & ~trk_onehot;
      end
      ST_PLAY:    play_mask = valid_q;
      default: ;
    endcase
  end

  assign ram_we     = write_en;
  assign ram_addr   = addr_q;
  assign ram_track  = trk_q;
  assign loop_len   = len_q;
  assign state_code = {1'b0, state_q};
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_beat_loop_ctrl.sv
module tb_beat_loop_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: 4 tracks, 1024-sample tracks
  logic        m_rst, m_tick, m_clr;
  logic [1:0]  m_mode, m_tsel;
  logic        m_we, m_kb, m_ovf;
  logic [9:0]  m_addr;
  logic [1:0]  m_trk;
  logic [3:0]  m_mask, m_st;
  logic [10:0] m_len;

  beat_loop_ctrl #(.NUM_TRACKS(4), .ADDR_W(10)) dut (
    .CLOCK_50(clk), .reset(m_rst), .tick(m_tick), .mode_req(m_mode),
    .track_sel(m_tsel), .clear(m_clr), .ram_we(m_we), .ram_addr(m_addr),
    .ram_track(m_trk), .keyboard_record(m_kb), .play_mask(m_mask),
    .loop_len(m_len), .state_code(m_st), .overflow(m_ovf)
  );

  // Small instance: 8-sample tracks for the overflow case
  logic        s_rst, s_tick, s_clr;
  logic [1:0]  s_mode, s_tsel;
  logic        s_we, s_kb, s_ovf;
  logic [2:0]  s_addr;
  logic [1:0]  s_trk;
  logic [3:0]  s_mask, s_st;
  logic [3:0]  s_len;

  beat_loop_ctrl #(.NUM_TRACKS(4), .ADDR_W(3)) dut_small (
    .CLOCK_50(clk), .reset(s_rst), .tick(s_tick), .mode_req(s_mode),
    .track_sel(s_tsel), .clear(s_clr), .ram_we(s_we), .ram_addr(s_addr),
    .ram_track(s_trk), .keyboard_record(s_kb), .play_mask(s_mask),
    .loop_len(s_len), .state_code(s_st), .overflow(s_ovf)
  );

  typedef struct {
    logic [1:0] mode;
    logic [1:0] tsel;
    logic       tick;
    logic       clr;
    logic       we;
    int         addr;
    int         st;
    logic [3:0] mask;
    int         len;
    int         trk;   // -1: ram_track not checked
  } vec_t;

  vec_t tbl[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] mode, input logic [1:0] tsel, input logic tick,
                     input logic clr, input logic we, input int addr, input int st,
                     input logic [3:0] mask, input int len, input int trk);
    vec_t v;
    v.mode = mode; v.tsel = tsel; v.tick = tick; v.clr = clr; v.we = we;
    v.addr = addr; v.st = st; v.mask = mask; v.len = len; v.trk = trk;
    tbl.push_back(v);
  endtask

  task automatic s_cyc(input logic [1:0] mode, input logic tick);
    @(negedge clk);
    s_mode = mode;
    s_tick = tick;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    m_rst = 1'b1; m_tick = 1'b0; m_clr = 1'b0; m_mode = 2'b00; m_tsel = 2'd0;
    s_rst = 1'b1; s_tick = 1'b0; s_clr = 1'b0; s_mode = 2'b00; s_tsel = 2'd0;

    // Columns: mode tsel tick clr | we addr state mask len trk
    // Record 5 samples on track 0
    add(2'b00, 0, 0, 0, 0, 0, 0, 4'b0000, 0, -1);
    add(2'b01, 0, 0, 0, 0, 0, 0, 4'b0000, 0, -1);
    add(2'b01, 0, 0, 0, 0, 0, 4, 4'b0000, 0, -1);
    add(2'b01, 0, 1, 0, 0, 0, 4, 4'b0000, 0, -1);
    for (int i = 0; i < 5; i++) add(2'b01, 0, 1, 0, 1, i, 1, 4'b0000, 0, 0);
    add(2'b00, 0, 0, 0, 0, 5, 1, 4'b0000, 0, -1);
    add(2'b00, 0, 0, 0, 0, 0, 0, 4'b0000, 5, -1);
    // Play 12 ticks, loop wraps at 5
    add(2'b10, 0, 0, 0, 0, 0, 0, 4'b0000, 5, -1);
    for (int i = 0; i < 12; i++) add(2'b10, 0, 1, 0, 0, i % 5, 3, 4'b0001, 5, -1);
    add(2'b00, 0, 0, 0, 0, 2, 3, 4'b0001, 5, -1);
    // Overdub track 2 for 7 ticks; track_sel changes after entry are ignored
    add(2'b11, 2, 0, 0, 0, 0, 0, 4'b0000, 5, -1);
    for (int i = 0; i < 7; i++) add(2'b11, 0, 1, 0, 1, i % 5, 2, 4'b0001, 5, 2);
    add(2'b00, 0, 0, 0, 0, 2, 2, 4'b0001, 5, -1);
    // Play shows tracks 0 and 2; clear in PLAY ignored
    add(2'b10, 0, 0, 0, 0, 0, 0, 4'b0000, 5, -1);
    add(2'b10, 0, 1, 0, 0, 0, 3, 4'b0101, 5, -1);
    add(2'b10, 0, 0, 1, 0, 1, 3, 4'b0101, 5, -1);
    add(2'b00, 0, 0, 0, 0, 1, 3, 4'b0101, 5, -1);
    add(2'b00, 0, 0, 0, 0, 0, 0, 4'b0000, 5, -1);
    // Overdub track 1 once, then release together with a tick (dropped)
    add(2'b11, 1, 0, 0, 0, 0, 0, 4'b0000, 5, -1);
    add(2'b11, 1, 1, 0, 1, 0, 2, 4'b0101, 5, 1);
    add(2'b00, 1, 1, 0, 0, 1, 2, 4'b0101, 5, -1);
    add(2'b00, 0, 0, 0, 0, 0, 0, 4'b0000, 5, -1);
    add(2'b10, 0, 0, 0, 0, 0, 0, 4'b0000, 5, -1);
    add(2'b10, 0, 0, 0, 0, 0, 3, 4'b0111, 5, -1);
    add(2'b00, 0, 0, 0, 0, 0, 3, 4'b0111, 5, -1);
    // Clear in FREE, then play/overdub requests with no loop stay in FREE
    add(2'b00, 0, 0, 1, 0, 0, 0, 4'b0000, 5, -1);
    add(2'b00, 0, 0, 0, 0, 0, 0, 4'b0000, 0, -1);
    add(2'b10, 0, 0, 0, 0, 0, 0, 4'b0000, 0, -1);
    add(2'b10, 0, 0, 0, 0, 0, 0, 4'b0000, 0, -1);
    add(2'b11, 0, 1, 0, 0, 0, 0, 4'b0000, 0, -1);
    add(2'b00, 0, 0, 0, 0, 0, 0, 4'b0000, 0, -1);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("reset state", m_st, 0);
    chk("reset loop_len", m_len, 0);
    chk("reset play_mask", m_mask, 0);
    chk("reset ram_we", m_we, 0);
    chk("reset ram_addr", m_addr, 0);
    chk("reset overflow", m_ovf, 0);
    chk("reset kb", m_kb, 0);
    m_rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      m_mode = tbl[i].mode; m_tsel = tbl[i].tsel; m_tick = tbl[i].tick; m_clr = tbl[i].clr;
      #1;
      chk($sformatf("row%0d ram_we", i), m_we, tbl[i].we);
      chk($sformatf("row%0d ram_addr", i), m_addr, tbl[i].addr);
      chk($sformatf("row%0d state", i), m_st, tbl[i].st);
      chk($sformatf("row%0d play_mask", i), m_mask, tbl[i].mask);
      chk($sformatf("row%0d loop_len", i), m_len, tbl[i].len);
      chk($sformatf("row%0d kb_rec", i), m_kb, (tbl[i].st == 1 || tbl[i].st == 2) ? 1 : 0);
      if (tbl[i].trk >= 0) chk($sformatf("row%0d ram_track", i), m_trk, tbl[i].trk);
    end

    // Overflow on 8-sample tracks
    @(negedge clk);
    s_rst = 1'b0;
    s_cyc(2'b01, 1'b0);
    chk("ovf idle state", s_st, 0);
    s_cyc(2'b01, 1'b1);
    chk("ovf arm state", s_st, 4);
    chk("ovf arm no write", s_we, 0);
    for (int i = 0; i < 8; i++) begin
      s_cyc(2'b01, 1'b1);
      chk($sformatf("ovf wr%0d we", i), s_we, 1);
      chk($sformatf("ovf wr%0d addr", i), s_addr, i);
      chk($sformatf("ovf wr%0d state", i), s_st, 1);
      chk($sformatf("ovf wr%0d flag", i), s_ovf, 0);
    end
    s_cyc(2'b01, 1'b1);
    chk("ovf 9th tick we", s_we, 0);
    chk("ovf auto free", s_st, 0);
    chk("ovf loop_len", s_len, 8);
    chk("ovf flag", s_ovf, 1);
    s_cyc(2'b00, 1'b0);
    chk("ovf rearm state", s_st, 4);
    s_cyc(2'b10, 1'b0);
    chk("ovf back free", s_st, 0);
    chk("ovf flag sticky", s_ovf, 1);
    s_cyc(2'b10, 1'b0);
    chk("ovf play state", s_st, 3);
    chk("ovf play mask", s_mask, 4'b0001);

    // Reset in the middle of play
    @(negedge clk);
    s_rst = 1'b1;
    #1;
    chk("midrst pre state", s_st, 3);
    @(negedge clk);
    s_rst = 1'b0;
    s_mode = 2'b00;
    #1;
    chk("midrst state", s_st, 0);
    chk("midrst loop_len", s_len, 0);
    chk("midrst overflow", s_ovf, 0);
    chk("midrst mask", s_mask, 0);
    chk("midrst addr", s_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
